// File: rtl/hann_fft_pingpong_buf_if.sv
// Handshake and data bundle between the window stage, the FFT reader
// and the ping-pong frame store.
interface hann_fft_pingpong_buf_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) ();
  logic              clear;
  logic              wr_auto;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_valid;
  logic              wr_last;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_frame_valid;
  logic              rd_done;
  logic              overflow;
  logic [CNT_W-1:0]  drop_count;
  logic [CNT_W-1:0]  frame_count;

  modport master (
    output clear, wr_auto, wr_data, wr_addr,
    output wr_valid, wr_last, rd_addr, rd_done,
    input  wr_ready, rd_data, rd_frame_valid,
    input  overflow, drop_count, frame_count
  );

  modport slave (
    input  clear, wr_auto, wr_data, wr_addr,
    input  wr_valid, wr_last, rd_addr, rd_done,
    output wr_ready, rd_data, rd_frame_valid,
    output overflow, drop_count, frame_count
  );
endinterface

// File: rtl/hann_fft_pingpong_buf.sv
// Double-buffered frame store: windowing fills one bank while the FFT
// reads the other; writes to a busy bank are dropped and counted.
module hann_fft_pingpong_buf #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 4096,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic reset_n,
  hann_fft_pingpong_buf_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];

  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_mode;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_ovf;
  logic [CNT_W-1:0]  r_drop;
  logic [CNT_W-1:0]  r_fcnt;

  logic              w_wr_ready;
  logic              w_acc;
  logic              w_drop;
  logic              w_end;
  logic              w_rel;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_full_nxt;

  assign w_wr_ready = !r_full[r_wr_sel];
  assign w_acc  = bus.wr_valid && w_wr_ready && !bus.clear;
  assign w_drop = bus.wr_valid && !w_wr_ready && !bus.clear;
  assign w_addr = r_mode ? r_wr_ptr : bus.wr_addr;
  assign w_end  = w_acc &&
    (r_mode ? (r_wr_ptr == LAST_PTR) : bus.wr_last);
  assign w_rel  = bus.rd_done && r_full[r_rd_sel];

  // Commit and release never hit the same bank, so both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_end) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rel) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[{r_wr_sel, w_addr}] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= '0;
    end else if (!bus.clear) begin
      r_rd_data <= r_mem[{r_rd_sel, bus.rd_addr}];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_ptr <= '0;
      r_mode   <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
      r_fcnt   <= '0;
    end else if (bus.clear) begin
      r_full   <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_ptr <= '0;
      r_mode   <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
      r_fcnt   <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_end) r_wr_sel <= ~r_wr_sel;
      if (w_rel) r_rd_sel <= ~r_rd_sel;
      if (w_end) begin
        r_wr_ptr <= '0;
        r_fcnt   <= r_fcnt + 1'b1;
      end else if (w_acc && r_mode) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      // Mode is only latched between frames.
      if (r_wr_ptr == '0) r_mode <= bus.wr_auto;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
    end
  end

  assign bus.wr_ready       = w_wr_ready;
  assign bus.rd_data        = r_rd_data;
  assign bus.rd_frame_valid = r_full[r_rd_sel];
  assign bus.overflow       = r_ovf;
  assign bus.drop_count     = r_drop;
  assign bus.frame_count    = r_fcnt;
endmodule

// File: tb/tb_hann_fft_pingpong_buf.sv
// Directed bench: read data checked by a scoreboard queue and monitor,
// status flags checked directly at the falling edge.
module tb_hann_fft_pingpong_buf;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic rd_en = 1'b0;
  logic pend = 1'b0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  hann_fft_pingpong_buf_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) bus ();

  hann_fft_pingpong_buf #(
    .DATA_W(16), .ADDR_W(4), .FRAME_LEN(8), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  always @(posedge clk) pend <= rd_en;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_underflow got=%0h want=none", bus.rd_data);
      end else begin
        chk("rd_data", {16'h0, bus.rd_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] d, input logic [3:0] a,
                    input logic last, input logic done);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_addr  = a;
    bus.wr_last  = last;
    bus.rd_done  = done;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.rd_done  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] want);
    bus.rd_addr = a;
    rd_en = 1'b1;
    exp_q.push_back(want);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic done_pulse();
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
  endtask

  task automatic auto_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) wr(base + 16'(i), 4'd0, 1'b0, 1'b0);
  endtask

  task automatic read_frame(input logic [15:0] base);
    for (int i = 0; i < 8; i++) rd(4'(i), base + 16'(i));
  endtask

  task automatic chk_flags(input string nm, input logic rdy,
                           input logic fv, input logic ov,
                           input logic [15:0] dc, input logic [15:0] fc);
    chk({nm, "_wr_ready"}, {31'h0, bus.wr_ready}, {31'h0, rdy});
    chk({nm, "_frame_valid"}, {31'h0, bus.rd_frame_valid}, {31'h0, fv});
    chk({nm, "_overflow"}, {31'h0, bus.overflow}, {31'h0, ov});
    chk({nm, "_drop_count"}, {16'h0, bus.drop_count}, {16'h0, dc});
    chk({nm, "_frame_count"}, {16'h0, bus.frame_count}, {16'h0, fc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear = 1'b0;
    bus.wr_auto = 1'b0;
    bus.wr_data = '0;
    bus.wr_addr = '0;
    bus.wr_valid = 1'b0;
    bus.wr_last = 1'b0;
    bus.rd_addr = '0;
    bus.rd_done = 1'b0;
    idle();
    idle();
    #1;
    chk_flags("reset", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("reset_rd_data", {16'h0, bus.rd_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.wr_auto = 1'b1;
    idle();

    // auto frame into bank 0
    for (int i = 0; i < 7; i++) wr(16'(i), 4'd0, 1'b0, 1'b0);
    chk("pre_last_fv", {31'h0, bus.rd_frame_valid}, 32'h0);
    wr(16'd7, 4'd0, 1'b0, 1'b0);
    chk_flags("frame1", 1'b1, 1'b1, 1'b0, 16'd0, 16'd1);
    read_frame(16'd0);

    // second frame fills bank 1, then a drop
    auto_frame(16'd100);
    chk_flags("both_full", 1'b0, 1'b1, 1'b0, 16'd0, 16'd2);
    wr(16'd999, 4'd0, 1'b0, 1'b0);
    chk_flags("drop1", 1'b0, 1'b1, 1'b1, 16'd1, 16'd2);
    read_frame(16'd0);

    // release bank 0, read bank 1
    done_pulse();
    chk_flags("rel0", 1'b1, 1'b1, 1'b1, 16'd1, 16'd2);
    read_frame(16'd100);
    done_pulse();
    chk("rel1_fv", {31'h0, bus.rd_frame_valid}, 32'h0);

    // addressed mode, scattered addresses
    bus.wr_auto = 1'b0;
    idle();
    wr(16'h30, 4'd3, 1'b0, 1'b0);
    wr(16'h10, 4'd1, 1'b0, 1'b0);
    wr(16'h00, 4'd0, 1'b0, 1'b0);
    wr(16'h20, 4'd2, 1'b0, 1'b0);
    chk("addr_pre_fv", {31'h0, bus.rd_frame_valid}, 32'h0);
    wr(16'h40, 4'd4, 1'b1, 1'b0);
    chk_flags("addr_frame", 1'b1, 1'b1, 1'b1, 16'd1, 16'd3);
    rd(4'd3, 16'h30);
    rd(4'd1, 16'h10);
    rd(4'd0, 16'h00);
    rd(4'd2, 16'h20);
    rd(4'd4, 16'h40);
    wr(16'h55, 4'd0, 1'b1, 1'b0);
    chk_flags("addr_b1", 1'b0, 1'b1, 1'b1, 16'd1, 16'd4);
    wr(16'h66, 4'd1, 1'b1, 1'b0);
    chk_flags("drop_last", 1'b0, 1'b1, 1'b1, 16'd2, 16'd4);
    rd(4'd0, 16'h00);

    // commit of bank 1 coincides with release of bank 0
    done_pulse();
    done_pulse();
    chk("empty_fv", {31'h0, bus.rd_frame_valid}, 32'h0);
    bus.wr_auto = 1'b1;
    idle();
    auto_frame(16'd200);
    for (int i = 0; i < 7; i++) wr(16'd210 + 16'(i), 4'd0, 1'b0, 1'b0);
    wr(16'd217, 4'd0, 1'b0, 1'b1);
    chk_flags("same_cyc", 1'b1, 1'b1, 1'b1, 16'd2, 16'd6);
    read_frame(16'd210);

    // drive drop_count to 5, then soft clear
    auto_frame(16'd400);
    chk_flags("full_again", 1'b0, 1'b1, 1'b1, 16'd2, 16'd7);
    for (int i = 0; i < 3; i++) wr(16'hdead, 4'd0, 1'b0, 1'b0);
    chk_flags("drop5", 1'b0, 1'b1, 1'b1, 16'd5, 16'd7);
    bus.clear = 1'b1;
    idle();
    bus.clear = 1'b0;
    chk_flags("clear", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);

    // asynchronous reset mid-frame
    idle();
    for (int i = 0; i < 3; i++) wr(16'd500 + 16'(i), 4'd0, 1'b0, 1'b0);
    chk("mid_fc", {16'h0, bus.frame_count}, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_flags("async_rst", 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    chk("async_rst_rd_data", {16'h0, bus.rd_data}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    auto_frame(16'd600);
    chk_flags("post_rst", 1'b1, 1'b1, 1'b0, 16'd0, 16'd1);
    read_frame(16'd600);

    idle();
    idle();
    chk("sb_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
